control_sequencer: RTL and testbench
====================================

# control_sequencer

Hard-wired control unit for the 32-bit bus-based datapath. Decodes the opcode in IR[31:27] and steps a state machine through fetch (T0–T2) and per-class execute steps (T3–T7). Each step drives the datapath's bus-driver, register-load, ALU-select and memory strobes. It sits beside the DataPath instance and replaces the hand-sequenced strobes the benches drive today.

## Interface
- MEM_WAIT_MAX, 16: max cycles a memory step waits for Mem_ready before faulting (1..255)
- Clock  input  1  system clock, rising edge
- Clear  input  1  synchronous active-high reset
- Start  input  1  leave IDLE and begin fetching; sampled only in IDLE
- IR  input  32  instruction register contents from datapath
- Mem_ready  input  1  memory has completed the current Read/Write
- PCout, MDRout, Zlowout, ZHighout, HIout, LOout, BAout, Cout  output  1 each  bus-driver enables
- PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin  output  1 each  register loads
- Gra, Grb, Grc, Rin, Rout  output  1 each  register-field select and GPR load/drive
- IncPC, Read, Write  output  1 each  PC increment, memory read/write request
- alu_op  output  5  ALU operation code
- Run  output  1  high while fetching or executing
- Done  output  1  one-cycle pulse in final step of each instruction
- Fault  output  1  sticky memory-timeout flag, cleared only by Clear

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT. Outputs are combinational decodes of state and IR only. All strobes not listed for a step are 0.
- Reset (Clear high at edge): state=IDLE, wait counter=0, Fault=0. All outputs are 0, including Run. Clear overrides Start and Mem_ready in every state, including mid-instruction.
- IDLE → T0 on Start=1. Start is ignored in every other state.
- T0: PCout, MARin, IncPC, ZLowIn.
- T1: Zlowout, PCin, Read, MDRin. This is a memory step.
- T2: MDRout, IRin.
- Decode uses IR at T3 (loaded at end of T2). Opcodes:
  - ld 00000, ldi 00001, st 00010
  - add..shl 00011–01011
  - addi 01100, andi 01101, ori 01110
  - div 01111, mul 10000, neg 10001, not 10010
  - jr 10100, mfhi 11000, mflo 11001, nop 11010, halt 11011
  - All other opcodes execute as nop.
- nop: T2 asserts Done, next T0.
- Reg-reg ALU (00011–01011): T3 Grb Rout Yin; T4 Grc Rout ZLowIn with alu_op=opcode; T5 Zlowout Gra Rin Done.
- neg/not: T3 Grb Rout ZLowIn with alu_op=opcode; T4 Zlowout Gra Rin Done.
- Immediate (addi/andi/ori): T3 Grb Rout Yin; T4 Cout ZLowIn with alu_op=opcode; T5 Zlowout Gra Rin Done.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout ZLowIn ZHighIn with alu_op=opcode; T5 Zlowout LOin; T6 ZHighout HIin Done.
- ldi: T3 Grb BAout Yin; T4 Cout ZLowIn with alu_op=00011; T5 Zlowout Gra Rin Done.
- ld: T3–T4 as ldi; T5 Zlowout MARin; T6 Read MDRin (memory step); T7 MDRout Gra Rin Done.
- st: T3–T5 as ld; T6 Gra Rout MDRin; T7 Write Done (memory step).
- jr: T3 Gra Rout PCin Done.
- mfhi: T3 HIout Gra Rin Done. mflo: T3 LOout Gra Rin Done.
- halt: T3 Done, then HALT. HALT holds until Clear, with Run=0.
- After Done, next state is T0.
- alu_op is 0 in every step not listed above.
- Run=1 in T0–T7. Run=0 in IDLE and HALT.

## Timing
- Memory steps (T1, ld T6, st T7): the state and its strobes hold while Mem_ready=0. The FSM advances on the first edge with Mem_ready=1. Done in st T7 asserts only in the cycle Mem_ready=1.
- Wait counter: resets on entry to each memory step and increments per stalled cycle. If it reaches MEM_WAIT_MAX with Mem_ready still 0, the FSM goes to HALT with Fault=1 on the next edge.
- Cycle counts with Mem_ready tied high:
  - nop: 3
  - jr, mfhi, mflo, halt: 4
  - neg, not: 5
  - reg-reg ALU, immediate, ldi: 6
  - mul, div: 7
  - ld, st: 8
- Back-to-back: T0 of the next instruction is in the cycle immediately after Done.
- A Clear asserted in any step aborts the instruction. Outputs are 0 from the cycle after the Clear edge, with no partial register writes.

## Test plan
- Clear, Start, IR=0x28918000 (and R1,R2,R3), Mem_ready=1 → T0..T5 in 6 cycles. T4 has alu_op=00101, Grc, Rout, ZLowIn. T5 has Zlowout, Gra, Rin, Done. Next cycle is T0.
- IR opcode 10001 (neg) → T3 has alu_op=10001 with ZLowIn. Done in T4, 5 cycles total.
- ld with Mem_ready low for 3 cycles in T6 → T6 is held 4 cycles with Read and MDRin steady. T7 follows, then Done. Fault=0.
- Mem_ready stuck low in T1 with MEM_WAIT_MAX=16 → HALT after 16 stalled cycles. Fault=1, Run=0. Start is then ignored until Clear.
- Clear pulsed during T4 of mul → next cycle IDLE, all outputs 0, Run=0. Start restarts at T0.
- halt (11011) followed by Start pulses → Done in T3, then HALT persists with Run=0 and no strobes.

Source files
------------

// File: rtl/control_sequencer.sv
// Hard-wired control unit for the 32-bit bus datapath: fetch in T0-T2, then
// opcode-dependent execute steps in T3-T7, with memory-step stall/timeout handling.
module control_sequencer #(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Start,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        HIout,
  output logic        LOout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HIin,
  output logic        LOin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        Run,
  output logic        Done,
  output logic        Fault,
  output logic [3:0]  dbg_state
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] T0   = 4'd1;
  localparam logic [3:0] T1   = 4'd2;
  localparam logic [3:0] T2   = 4'd3;
  localparam logic [3:0] T3   = 4'd4;
  localparam logic [3:0] T4   = 4'd5;
  localparam logic [3:0] T5   = 4'd6;
  localparam logic [3:0] T6   = 4'd7;
  localparam logic [3:0] T7   = 4'd8;
  localparam logic [3:0] HALT = 4'd9;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [7:0] wait_cnt;
  logic [4:0] op;
  logic       unused_ir;

  logic c_ld, c_ldi, c_st, c_alu, c_imm, c_muldiv, c_negnot;
  logic c_jr, c_mfhi, c_mflo, c_halt, c_nop;
  logic mem_step, stall, timeout;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign dbg_state = state;

  always_comb begin
    c_ld     = (op == 5'd0);
    c_ldi    = (op == 5'd1);
    c_st     = (op == 5'd2);
    c_alu    = (op >= 5'd3) && (op <= 5'd11);
    c_imm    = (op >= 5'd12) && (op <= 5'd14);
    c_muldiv = (op == 5'd15) || (op == 5'd16);
    c_negnot = (op == 5'd17) || (op == 5'd18);
    c_jr     = (op == 5'd20);
    c_mfhi   = (op == 5'd24);
    c_mflo   = (op == 5'd25);
    c_halt   = (op == 5'd27);
    // Explicit nop and every unassigned opcode finish at the end of fetch.
    c_nop    = !(c_ld || c_ldi || c_st || c_alu || c_imm || c_muldiv ||
                 c_negnot || c_jr || c_mfhi || c_mflo || c_halt);
  end

  // Memory handshake: the step's Read/Write request stays asserted and the
  // state holds while Mem_ready=0; the step completes on the first edge that
  // samples Mem_ready=1. Mem_ready is ignored outside memory steps.
  assign mem_step = (state == T1) || ((state == T6) && c_ld) || ((state == T7) && c_st);
  assign stall    = mem_step && !Mem_ready;
  assign timeout  = stall && (wait_cnt == WAIT_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (Start) next_state = T0;
      T0:   next_state = T1;
      T1:   next_state = T2;
      T2:   next_state = c_nop ? T0 : T3;
      T3: begin
        if (c_jr || c_mfhi || c_mflo) next_state = T0;
        else if (c_halt)              next_state = HALT;
        else                          next_state = T4;
      end
      T4:   next_state = c_negnot ? T0 : T5;
      T5:   next_state = (c_alu || c_imm || c_ldi) ? T0 : T6;
      T6:   next_state = c_muldiv ? T0 : T7;
      T7:   next_state = T0;
      HALT: next_state = HALT;
      default: next_state = IDLE;
    endcase
    if (stall) next_state = timeout ? HALT : state;
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      Fault    <= 1'b0;
    end else begin
      state <= next_state;
      if (stall && !timeout) wait_cnt <= wait_cnt + 8'd1;
      else                   wait_cnt <= 8'd0;
      if (timeout) Fault <= 1'b1;
    end
  end

  always_comb begin
    PCout = 1'b0; MDRout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; BAout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    ZLowIn = 1'b0; ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op = 5'd0;
    Done = 1'b0;
    Run = (state >= T0) && (state <= T7);
    case (state)
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1; Done = c_nop;
      end
      T3: begin
        if (c_alu || c_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (c_negnot) begin
          Grb = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; alu_op = op;
        end else if (c_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (c_ld || c_ldi || c_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (c_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; Done = 1'b1;
        end else if (c_mfhi) begin
          HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
        end else if (c_mflo) begin
          LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
        end else if (c_halt) begin
          Done = 1'b1;
        end
      end
      T4: begin
        if (c_alu) begin
          Grc = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; alu_op = op;
        end else if (c_negnot) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
        end else if (c_imm) begin
          Cout = 1'b1; ZLowIn = 1'b1; alu_op = op;
        end else if (c_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; alu_op = op;
        end else if (c_ld || c_ldi || c_st) begin
          // Base-plus-offset address is formed with the add operation.
          Cout = 1'b1; ZLowIn = 1'b1; alu_op = 5'b00011;
        end
      end
      T5: begin
        if (c_alu || c_imm || c_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
        end else if (c_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (c_ld || c_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end
      end
      T6: begin
        if (c_muldiv) begin
          ZHighout = 1'b1; HIin = 1'b1; Done = 1'b1;
        end else if (c_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (c_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end
      end
      T7: begin
        if (c_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; Done = 1'b1;
        end else if (c_st) begin
          Write = 1'b1; Done = Mem_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe words are built
// from the opcode-class step table and compared cycle by cycle.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] IR = 32'd0;
  logic        Mem_ready = 1'b1;
  logic PCout, MDRout, Zlowout, ZHighout, HIout, LOout, BAout, Cout;
  logic PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;
  logic [4:0] alu_op;
  logic Run, Done, Fault;
  logic [3:0] dbg_state;
  logic [31:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        rdy_q[$];

  localparam logic [31:0] PCOUT    = 32'h8000_0000;
  localparam logic [31:0] MDROUT   = 32'h4000_0000;
  localparam logic [31:0] ZLOWOUT  = 32'h2000_0000;
  localparam logic [31:0] ZHIGHOUT = 32'h1000_0000;
  localparam logic [31:0] HIOUT    = 32'h0800_0000;
  localparam logic [31:0] LOOUT    = 32'h0400_0000;
  localparam logic [31:0] BAOUT    = 32'h0200_0000;
  localparam logic [31:0] COUT     = 32'h0100_0000;
  localparam logic [31:0] PCIN     = 32'h0080_0000;
  localparam logic [31:0] MARIN    = 32'h0040_0000;
  localparam logic [31:0] MDRIN    = 32'h0020_0000;
  localparam logic [31:0] IRIN     = 32'h0010_0000;
  localparam logic [31:0] YIN      = 32'h0008_0000;
  localparam logic [31:0] ZLOWIN   = 32'h0004_0000;
  localparam logic [31:0] ZHIGHIN  = 32'h0002_0000;
  localparam logic [31:0] HIIN     = 32'h0001_0000;
  localparam logic [31:0] LOIN     = 32'h0000_8000;
  localparam logic [31:0] GRA      = 32'h0000_4000;
  localparam logic [31:0] GRB      = 32'h0000_2000;
  localparam logic [31:0] GRC      = 32'h0000_1000;
  localparam logic [31:0] RIN      = 32'h0000_0800;
  localparam logic [31:0] ROUT     = 32'h0000_0400;
  localparam logic [31:0] INCPC    = 32'h0000_0200;
  localparam logic [31:0] READ     = 32'h0000_0100;
  localparam logic [31:0] WRITE    = 32'h0000_0080;
  localparam logic [31:0] RUN      = 32'h0000_0040;
  localparam logic [31:0] DONE     = 32'h0000_0020;

  control_sequencer #(.MEM_WAIT_MAX(16)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .IR(IR), .Mem_ready(Mem_ready),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .ZHighout(ZHighout),
    .HIout(HIout), .LOout(LOout), .BAout(BAout), .Cout(Cout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write), .alu_op(alu_op),
    .Run(Run), .Done(Done), .Fault(Fault), .dbg_state(dbg_state)
  );

  assign obs = {PCout, MDRout, Zlowout, ZHighout, HIout, LOout, BAout, Cout,
                PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin,
                Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Run, Done, alu_op};

  always #5 Clock = ~Clock;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One running-step word per cycle, plus the Mem_ready value driven that cycle.
  function automatic void push(input logic [31:0] w, input logic rdy);
    exp_q.push_back(w | RUN);
    rdy_q.push_back(rdy);
  endfunction

  // Reference model: expected step words for one instruction.
  // s1 = stalled cycles in fetch read, sm = stalled cycles in the ld/st memory step.
  function automatic void build(input logic [4:0] op, input int s1, input int sm);
    logic [31:0] a;
    logic [31:0] add_op;
    a = {27'd0, op};
    add_op = 32'd3;
    push(PCOUT | MARIN | INCPC | ZLOWIN, rb());
    for (int i = 0; i < s1; i++) push(ZLOWOUT | PCIN | READ | MDRIN, 1'b0);
    push(ZLOWOUT | PCIN | READ | MDRIN, 1'b1);
    if (!(op inside {[5'd0:5'd18], 5'd20, 5'd24, 5'd25, 5'd27})) begin
      push(MDROUT | IRIN | DONE, rb());
      return;
    end
    push(MDROUT | IRIN, rb());
    if (op inside {[5'd3:5'd11]}) begin
      push(GRB | ROUT | YIN, rb());
      push(GRC | ROUT | ZLOWIN | a, rb());
      push(ZLOWOUT | GRA | RIN | DONE, rb());
    end else if (op inside {[5'd12:5'd14]}) begin
      push(GRB | ROUT | YIN, rb());
      push(COUT | ZLOWIN | a, rb());
      push(ZLOWOUT | GRA | RIN | DONE, rb());
    end else if (op == 5'd17 || op == 5'd18) begin
      push(GRB | ROUT | ZLOWIN | a, rb());
      push(ZLOWOUT | GRA | RIN | DONE, rb());
    end else if (op == 5'd15 || op == 5'd16) begin
      push(GRA | ROUT | YIN, rb());
      push(GRB | ROUT | ZLOWIN | ZHIGHIN | a, rb());
      push(ZLOWOUT | LOIN, rb());
      push(ZHIGHOUT | HIIN | DONE, rb());
    end else if (op <= 5'd2) begin
      push(GRB | BAOUT | YIN, rb());
      push(COUT | ZLOWIN | add_op, rb());
      if (op == 5'd1) begin
        push(ZLOWOUT | GRA | RIN | DONE, rb());
      end else begin
        push(ZLOWOUT | MARIN, rb());
        if (op == 5'd0) begin
          for (int i = 0; i < sm; i++) push(READ | MDRIN, 1'b0);
          push(READ | MDRIN, 1'b1);
          push(MDROUT | GRA | RIN | DONE, rb());
        end else begin
          push(GRA | ROUT | MDRIN, rb());
          for (int i = 0; i < sm; i++) push(WRITE, 1'b0);
          push(WRITE | DONE, 1'b1);
        end
      end
    end else if (op == 5'd20) begin
      push(GRA | ROUT | PCIN | DONE, rb());
    end else if (op == 5'd24) begin
      push(HIOUT | GRA | RIN | DONE, rb());
    end else if (op == 5'd25) begin
      push(LOOUT | GRA | RIN | DONE, rb());
    end else begin
      push(DONE, rb());
    end
  endfunction

  // Driver: applies queued Mem_ready values and checks queued words; n<0 runs all.
  task automatic run_queue(input string name, input int n);
    int idx;
    idx = 0;
    while (exp_q.size() > 0 && (n < 0 || idx < n)) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      Mem_ready = rdy_q.pop_front();
      @(negedge Clock);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s step %0d op=%b: got %h want %h", name, idx, IR[31:27], obs, e);
      end
      @(posedge Clock); #1;
      idx++;
    end
    exp_q.delete();
    rdy_q.delete();
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    @(posedge Clock); #1;
    Clear = 1'b0;
    Start = 1'b0;
  endtask

  task automatic start_from_idle();
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic check_idle(input string name, input logic want_fault);
    @(negedge Clock);
    n_tests++;
    if (obs !== 32'd0 || Fault !== want_fault) begin
      n_fail++;
      $display("FAIL %s: got outputs %h fault %b want 0 fault %b", name, obs, Fault, want_fault);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    Clear = 1'b1; Start = 1'b1; Mem_ready = 1'b1; IR = $urandom;
    @(posedge Clock); @(posedge Clock); #1;
    @(negedge Clock);
    n_tests++;
    if (obs !== 32'd0 || Fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got outputs %h fault %b want 0 fault 0", obs, Fault);
    end
    @(posedge Clock); #1;
    Clear = 1'b0; Start = 1'b0;
    for (int i = 0; i < 3; i++) check_idle("idle_hold", 1'b0);
  endtask

  task automatic test_directed();
    logic [4:0] ops[13];
    ops = '{5'd5, 5'd17, 5'd0, 5'd2, 5'd1, 5'd12, 5'd15, 5'd16, 5'd20, 5'd24, 5'd25, 5'd26, 5'd19};
    do_clear();
    start_from_idle();
    IR = 32'h2891_8000;
    build(IR[31:27], 0, 0);
    run_queue("and_r1_r2_r3", -1);
    foreach (ops[i]) begin
      IR = {ops[i], 27'($urandom)};
      build(ops[i], 0, (ops[i] == 5'd0) ? 3 : 2);
      run_queue("directed", -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    do_clear();
    start_from_idle();
    for (int i = 0; i < 60; i++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
      IR = {op, 27'($urandom)};
      build(op, $urandom_range(0, 3), $urandom_range(0, 4));
      run_queue("random", -1);
    end
    @(negedge Clock);
    n_tests++;
    if (Fault !== 1'b0) begin
      n_fail++;
      $display("FAIL no_fault_after_stalls: got %b want 0", Fault);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_timeout();
    do_clear();
    start_from_idle();
    IR = {5'd3, 27'($urandom)};
    push(PCOUT | MARIN | INCPC | ZLOWIN, 1'b1);
    for (int i = 0; i < 16; i++) push(ZLOWOUT | PCIN | READ | MDRIN, 1'b0);
    run_queue("t1_stall", -1);
    check_idle("timeout_halt", 1'b1);
    for (int i = 0; i < 3; i++) begin
      Start = 1'b1; Mem_ready = rb();
      check_idle("halt_ignores_start", 1'b1);
      Start = 1'b0;
    end
    Mem_ready = 1'b1;
    do_clear();
    check_idle("clear_after_fault", 1'b0);
  endtask

  task automatic test_clear_mid();
    do_clear();
    start_from_idle();
    IR = {5'd16, 27'($urandom)};
    build(5'd16, 0, 0);
    run_queue("mul_to_t3", 4);
    build(5'd16, 0, 0);
    for (int i = 0; i < 4; i++) begin
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
    end
    Clear = 1'b1;
    run_queue("mul_t4_with_clear", 1);
    Clear = 1'b0;
    check_idle("after_clear_idle", 1'b0);
    check_idle("after_clear_stays", 1'b0);
    start_from_idle();
    IR = {5'd17, 27'($urandom)};
    build(5'd17, 0, 0);
    run_queue("restart_neg", -1);
  endtask

  task automatic test_halt();
    do_clear();
    start_from_idle();
    IR = {5'd27, 27'($urandom)};
    build(5'd27, 1, 0);
    run_queue("halt_instr", -1);
    for (int i = 0; i < 4; i++) begin
      Start = rb(); Mem_ready = rb();
      check_idle("halt_hold", 1'b0);
    end
    Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_timeout();
    test_clear_mid();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
